// File: rtl/sqrt_job_scheduler.sv
// sqrt_job_scheduler: credit-tracked job pipeline, result FIFO and frame launcher.
// Optional macro SQRT_SCHED_STATS_EN adds stat_jobs/stat_drops counters.
module sqrt_job_scheduler #(
   parameter int DATA_W     = 32,
   parameter int PIPE_LAT   = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int TX_ACK_TO  = 3
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [DATA_W-1:0]           in_data,
   input  logic                        in_data_ready,
   output logic [DATA_W-1:0]           arith_in_s,
   input  logic [DATA_W-1:0]           arith_sqrt,
   output logic [DATA_W-1:0]           out_data,
   output logic                        out_data_ready,
   input  logic                        tx_idle,
   output logic                        drop_err,
`ifdef SQRT_SCHED_STATS_EN
   output logic [15:0]                 stat_jobs,
   output logic [7:0]                  stat_drops,
`endif
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int SW = $clog2(PIPE_LAT + FIFO_DEPTH + 1);
   localparam int TW = $clog2(TX_ACK_TO + 1);

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH_WAIT,
      FRAME_WAIT
   } state_t;

   state_t              state;
   logic [TW-1:0]       timer;
   logic [PIPE_LAT-1:0] vld;
   logic [SW-1:0]       credit_used;
   logic                accept;
   logic                refuse;
   logic                push;
   logic                pop;
   logic [AW-1:0]       wp;
   logic [AW-1:0]       rp;
   logic [DATA_W-1:0]   mem [FIFO_DEPTH];

   // Jobs in flight plus queued results may never exceed the FIFO depth.
   always_comb begin
      credit_used = SW'(fifo_level);
      for (int k = 0; k < PIPE_LAT; k++) begin
         credit_used = credit_used + SW'(vld[k]);
      end
   end

   assign accept = in_data_ready && (credit_used < SW'(FIFO_DEPTH));
   assign refuse = in_data_ready && !accept;
   assign push   = vld[PIPE_LAT-1];
   assign pop    = (state == IDLE) && (fifo_level != '0) && tx_idle;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld        <= '0;
         arith_in_s <= '0;
         drop_err   <= 1'b0;
      end else begin
         vld[0] <= accept;
         for (int k = 1; k < PIPE_LAT; k++) begin
            vld[k] <= vld[k-1];
         end
         if (accept) arith_in_s <= in_data;
         if (refuse) drop_err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wp] <= arith_sqrt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wp         <= '0;
         rp         <= '0;
         fifo_level <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         fifo_level <= fifo_level + LW'(push) - LW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         timer          <= '0;
         out_data       <= '0;
         out_data_ready <= 1'b0;
      end else begin
         out_data_ready <= 1'b0;
         unique case (state)
            IDLE: begin
               if (pop) begin
                  out_data       <= mem[rp];
                  out_data_ready <= 1'b1;
                  timer          <= '0;
                  state          <= LAUNCH_WAIT;
               end
            end
            LAUNCH_WAIT: begin
               if (!tx_idle) begin
                  state <= FRAME_WAIT;
               end else begin
                  // A transmitter that never goes busy is assumed finished.
                  timer <= timer + 1'b1;
                  if (timer == TW'(TX_ACK_TO - 1)) state <= IDLE;
               end
            end
            FRAME_WAIT: begin
               if (tx_idle) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SQRT_SCHED_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_jobs  <= '0;
         stat_drops <= '0;
      end else begin
         if (pop) stat_jobs <= stat_jobs + 1'b1;
         if (refuse && (stat_drops != 8'hff)) stat_drops <= stat_drops + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_sqrt_job_scheduler.sv
// Bench for sqrt_job_scheduler: vector table, directed corner cases,
// and random traffic checked against a job-level reference model.
`timescale 1ns/1ps
module tb_sqrt_job_scheduler;

   localparam int DW = 32;
   localparam int PL = 4;
   localparam int FD = 4;
   localparam int TO = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] in_data;
   logic          in_data_ready;
   logic [DW-1:0] arith_in_s;
   logic [DW-1:0] arith_sqrt;
   logic [DW-1:0] out_data;
   logic          out_data_ready;
   logic          tx_idle;
   logic          drop_err;
   logic [2:0]    fifo_level;
`ifdef SQRT_SCHED_STATS_EN
   logic [15:0]   stat_jobs;
   logic [7:0]    stat_drops;
`endif

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sqrt_job_scheduler #(
      .DATA_W(DW), .PIPE_LAT(PL), .FIFO_DEPTH(FD), .TX_ACK_TO(TO)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_data(in_data),
      .in_data_ready(in_data_ready),
      .arith_in_s(arith_in_s),
      .arith_sqrt(arith_sqrt),
      .out_data(out_data),
      .out_data_ready(out_data_ready),
      .tx_idle(tx_idle),
      .drop_err(drop_err),
`ifdef SQRT_SCHED_STATS_EN
      .stat_jobs(stat_jobs),
      .stat_drops(stat_drops),
`endif
      .fifo_level(fifo_level)
   );

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] isqrt(input logic [31:0] x);
      logic [31:0] r;
      longint unsigned t;
      r = '0;
      for (int b = 15; b >= 0; b--) begin
         t = {32'd0, r | (32'd1 << b)};
         if (t * t <= {32'd0, x}) r = r | (32'd1 << b);
      end
      return r;
   endfunction

   // Behavioural sqrt unit: result valid PL clocks after the operand register updates.
   logic [DW-1:0] sp [PL-1];
   always @(posedge clk) begin
      sp[0] <= isqrt(arith_in_s);
      for (int i = 1; i < PL - 1; i++) sp[i] <= sp[i-1];
   end
   assign arith_sqrt = sp[PL-2];

   // Job-level reference: outstanding = accepted - launched, results due PL edges after accept.
   int          cyc = 0;
   int unsigned accepted, launched, pushed;
   int          due_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] exp_ais, exp_od;
   logic        exp_drop, tx_pre;
   int          last_launch;
   int          drops_m, jobs_m;

   always @(posedge clk) begin
      cyc++;
      if (!rst_n) begin
         accepted = 0; launched = 0; pushed = 0;
         due_q.delete(); exp_q.delete();
         exp_ais = '0; exp_od = '0; exp_drop = 1'b0;
         drops_m = 0; jobs_m = 0; last_launch = -100;
      end else begin
         while (due_q.size() > 0 && due_q[0] <= cyc) begin
            void'(due_q.pop_front());
            pushed++;
         end
         if (in_data_ready) begin
            if (accepted - launched < FD) begin
               accepted++;
               exp_q.push_back(isqrt(in_data));
               exp_ais = in_data;
               due_q.push_back(cyc + PL);
            end else begin
               exp_drop = 1'b1;
               if (drops_m < 255) drops_m++;
            end
         end
      end
      tx_pre = tx_idle;
   end

   always @(negedge clk) begin
      if (out_data_ready) begin
         launched++;
         jobs_m++;
         if (exp_q.size() == 0) check("launch_with_empty_model", 32'd1, 32'd0);
         else exp_od = exp_q.pop_front();
         check("launch_tx_idle", 32'(tx_pre), 32'd1);
         check("launch_gap", 32'(cyc - last_launch >= 3), 32'd1);
         last_launch = cyc;
      end
      check("m_out_data", out_data, exp_od);
      check("m_arith_in_s", arith_in_s, exp_ais);
      check("m_drop_err", 32'(drop_err), 32'(exp_drop));
      check("m_fifo_level", 32'(fifo_level), pushed - launched);
      check("m_no_overflow", 32'(fifo_level <= FD), 32'd1);
`ifdef SQRT_SCHED_STATS_EN
      check("m_stat_jobs", 32'(stat_jobs), 32'(jobs_m[15:0]));
      check("m_stat_drops", 32'(stat_drops), 32'(drops_m));
`endif
   end

   task automatic step(input logic r, input logic i, input logic [31:0] d,
                       input logic t);
      rst_n = r; in_data_ready = i; in_data = d; tx_idle = t;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        idr;
      logic [31:0] din;
      logic        tx;
      logic [31:0] ais;
      logic        odr;
      logic [31:0] od;
      logic [2:0]  lvl;
      logic        drop;
   } vec_t;

   vec_t tv [31];

   int  w, pulses, rand_launch;
   logic got, req;
   logic t;
   int  tx_delay, tx_busy;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // idr din tx | ais odr od lvl drop
      tv[0]  = '{1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0,  3'd0, 1'b0};
      tv[1]  = '{1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0,  3'd0, 1'b0};
      tv[2]  = '{1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0,  3'd0, 1'b0};
      tv[3]  = '{1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0,  3'd0, 1'b0};
      tv[4]  = '{1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0,  3'd1, 1'b0};
      tv[5]  = '{1'b0, 32'h0,   1'b1, 32'h100, 1'b1, 32'h10, 3'd0, 1'b0};
      tv[6]  = '{1'b0, 32'h0,   1'b0, 32'h100, 1'b0, 32'h10, 3'd0, 1'b0};
      tv[7]  = '{1'b1, 32'd1,   1'b0, 32'd1,   1'b0, 32'h10, 3'd0, 1'b0};
      tv[8]  = '{1'b1, 32'd4,   1'b0, 32'd4,   1'b0, 32'h10, 3'd0, 1'b0};
      tv[9]  = '{1'b1, 32'd9,   1'b0, 32'd9,   1'b0, 32'h10, 3'd0, 1'b0};
      tv[10] = '{1'b1, 32'd16,  1'b0, 32'd16,  1'b0, 32'h10, 3'd0, 1'b0};
      tv[11] = '{1'b1, 32'd25,  1'b0, 32'd16,  1'b0, 32'h10, 3'd1, 1'b1};
      tv[12] = '{1'b0, 32'h0,   1'b0, 32'd16,  1'b0, 32'h10, 3'd2, 1'b1};
      tv[13] = '{1'b0, 32'h0,   1'b0, 32'd16,  1'b0, 32'h10, 3'd3, 1'b1};
      tv[14] = '{1'b0, 32'h0,   1'b0, 32'd16,  1'b0, 32'h10, 3'd4, 1'b1};
      tv[15] = '{1'b0, 32'h0,   1'b0, 32'd16,  1'b0, 32'h10, 3'd4, 1'b1};
      tv[16] = '{1'b0, 32'h0,   1'b1, 32'd16,  1'b0, 32'h10, 3'd4, 1'b1};
      tv[17] = '{1'b0, 32'h0,   1'b1, 32'd16,  1'b1, 32'd1,  3'd3, 1'b1};
      tv[18] = '{1'b0, 32'h0,   1'b1, 32'd16,  1'b0, 32'd1,  3'd3, 1'b1};
      tv[19] = '{1'b0, 32'h0,   1'b1, 32'd16,  1'b0, 32'd1,  3'd3, 1'b1};
      tv[20] = '{1'b0, 32'h0,   1'b1, 32'd16,  1'b0, 32'd1,  3'd3, 1'b1};
      tv[21] = '{1'b0, 32'h0,   1'b1, 32'd16,  1'b1, 32'd2,  3'd2, 1'b1};
      tv[22] = '{1'b0, 32'h0,   1'b1, 32'd16,  1'b0, 32'd2,  3'd2, 1'b1};
      tv[23] = '{1'b0, 32'h0,   1'b1, 32'd16,  1'b0, 32'd2,  3'd2, 1'b1};
      tv[24] = '{1'b0, 32'h0,   1'b1, 32'd16,  1'b0, 32'd2,  3'd2, 1'b1};
      tv[25] = '{1'b0, 32'h0,   1'b1, 32'd16,  1'b1, 32'd3,  3'd1, 1'b1};
      tv[26] = '{1'b0, 32'h0,   1'b1, 32'd16,  1'b0, 32'd3,  3'd1, 1'b1};
      tv[27] = '{1'b0, 32'h0,   1'b1, 32'd16,  1'b0, 32'd3,  3'd1, 1'b1};
      tv[28] = '{1'b0, 32'h0,   1'b1, 32'd16,  1'b0, 32'd3,  3'd1, 1'b1};
      tv[29] = '{1'b0, 32'h0,   1'b1, 32'd16,  1'b1, 32'd4,  3'd0, 1'b1};
      tv[30] = '{1'b0, 32'h0,   1'b1, 32'd16,  1'b0, 32'd4,  3'd0, 1'b1};

      step(1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      check("rst_arith_in_s", arith_in_s, 32'h0);
      check("rst_out_data", out_data, 32'h0);
      check("rst_out_data_ready", 32'(out_data_ready), 32'd0);
      check("rst_drop_err", 32'(drop_err), 32'd0);
      check("rst_fifo_level", 32'(fifo_level), 32'd0);

      for (int i = 0; i < 31; i++) begin
         step(1'b1, tv[i].idr, tv[i].din, tv[i].tx);
         check($sformatf("tv%0d_ais", i), arith_in_s, tv[i].ais);
         check($sformatf("tv%0d_odr", i), 32'(out_data_ready), 32'(tv[i].odr));
         check($sformatf("tv%0d_od", i), out_data, tv[i].od);
         check($sformatf("tv%0d_lvl", i), 32'(fifo_level), 32'(tv[i].lvl));
         check($sformatf("tv%0d_drop", i), 32'(drop_err), 32'(tv[i].drop));
      end
`ifdef SQRT_SCHED_STATS_EN
      check("tv_stat_drops", 32'(stat_drops), 32'd1);
      check("tv_stat_jobs", 32'(stat_jobs), 32'd5);
`endif

      // Busy transmitter holds off the next launch until it is idle again.
      step(1'b1, 1'b1, 32'h400, 1'b1);
      w = 0; got = 1'b0;
      while (!got && w < 20) begin
         step(1'b1, 1'b0, 32'h0, 1'b1);
         w++;
         got = out_data_ready;
      end
      check("busy_first_launch", 32'(got), 32'd1);
      check("busy_first_data", out_data, 32'h20);
      step(1'b1, 1'b1, 32'h900, 1'b0);
      pulses = 0;
      repeat (40) begin
         step(1'b1, 1'b0, 32'h0, 1'b0);
         if (out_data_ready) pulses++;
      end
      check("busy_no_launch", 32'(pulses), 32'd0);
      check("busy_level", 32'(fifo_level), 32'd1);
      step(1'b1, 1'b0, 32'h0, 1'b1);
      check("busy_release_edge", 32'(out_data_ready), 32'd0);
      step(1'b1, 1'b0, 32'h0, 1'b1);
      check("busy_release_launch", 32'(out_data_ready), 32'd1);
      check("busy_release_data", out_data, 32'h30);

      // Idle transmitter: push and pop coincide, then timeout spacing.
      step(1'b1, 1'b1, 32'd25, 1'b1);
      step(1'b1, 1'b1, 32'd36, 1'b1);
      w = 0; got = 1'b0;
      while (!got && w < 20) begin
         step(1'b1, 1'b0, 32'h0, 1'b1);
         w++;
         got = out_data_ready;
      end
      check("pushpop_launch", 32'(got), 32'd1);
      check("pushpop_data", out_data, 32'd5);
      check("pushpop_level", 32'(fifo_level), 32'd1);
      w = 0; got = 1'b0;
      while (!got && w < 20) begin
         step(1'b1, 1'b0, 32'h0, 1'b1);
         w++;
         got = out_data_ready;
      end
      check("timeout_gap", 32'(w), 32'(TO + 1));
      check("timeout_data", out_data, 32'd6);

      // Reset with one result queued and two jobs still in the pipe.
      step(1'b1, 1'b1, 32'h31, 1'b0);
      step(1'b1, 1'b1, 32'h40, 1'b0);
      step(1'b1, 1'b1, 32'h51, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      check("rstmid_pre_level", 32'(fifo_level), 32'd1);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      check("rstmid_level", 32'(fifo_level), 32'd0);
      check("rstmid_drop", 32'(drop_err), 32'd0);
      check("rstmid_odr", 32'(out_data_ready), 32'd0);
      pulses = 0;
      repeat (10) begin
         step(1'b1, 1'b0, 32'h0, 1'b1);
         if (out_data_ready) pulses++;
      end
      check("rstmid_no_launch", 32'(pulses), 32'd0);
      check("rstmid_level_after", 32'(fifo_level), 32'd0);

      // Random traffic with a reactive transmitter.
      tx_delay = 0; tx_busy = 0; rand_launch = 0;
      for (int c = 0; c < 1500; c++) begin
         req = ($urandom_range(0, 99) < 45);
         if (tx_delay > 0) begin
            tx_delay--;
            t = 1'b1;
         end else if (tx_busy > 0) begin
            tx_busy--;
            t = 1'b0;
         end else begin
            t = 1'b1;
         end
         step(1'b1, req, $urandom, t);
         if (out_data_ready) begin
            rand_launch++;
            tx_delay = $urandom_range(0, 4);
            tx_busy = $urandom_range(1, 8);
         end
      end
      check("rand_wrap_exercised", 32'(rand_launch >= 3 * FD), 32'd1);
      repeat (60) step(1'b1, 1'b0, 32'h0, 1'b1);
      check("drain_level", 32'(fifo_level), 32'd0);
      check("drain_model_queue", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sqrt_job_scheduler.md
Name: sqrt_job_scheduler

Overview:
Sequences the pipelined square-root datapath between the byte-level frame receiver and the frame transmitter. It replaces the fixed start-delay shift with a tracked job pipeline:
- accepts 32-bit operands, drives them into the sqrt pipeline and tags them with a valid shift chain;
- captures results into a small FIFO;
- meters the results out to the transmitter, one frame at a time, with a busy/idle handshake.
Credit-based admission guarantees the result FIFO can never overflow.

Parameters:
DATA_W, 32, operand/result width
PIPE_LAT, 4, clocks from arith_in_s update to matching arith_sqrt valid (>=1)
FIFO_DEPTH, 4, result FIFO entries (power of 2, >=2)
TX_ACK_TO, 3, clocks to wait for tx_idle to fall after a launch before treating the frame as done

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
in_data  in  DATA_W  operand from data receiver
in_data_ready  in  1  one-cycle pulse, in_data valid
arith_in_s  out  DATA_W  registered operand to sqrt pipeline
arith_sqrt  in  DATA_W  result from sqrt pipeline
out_data  out  DATA_W  result to data transmitter, held stable during a frame
out_data_ready  out  1  one-cycle launch pulse to data transmitter
tx_idle  in  1  high when transmitter has no frame in progress
drop_err  out  1  sticky: a job was refused for lack of credit
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
Reset (rst_n=0 at an edge):
- arith_in_s=0, out_data=0, out_data_ready=0, drop_err=0, fifo_level=0.
- Valid chain cleared, FIFO empty, state IDLE.
- Reset mid-operation discards in-flight jobs and any frame being launched; no pulse is emitted on the reset cycle or the following cycle.

Admission:
- inflight = number of set bits in vld[PIPE_LAT-1:0].
- A job is accepted at an edge with in_data_ready=1 when inflight + fifo_level < FIFO_DEPTH, evaluated with pre-edge values.
- Accept: arith_in_s<=in_data; vld[0]<=1.
- Refuse: job discarded, arith_in_s unchanged, drop_err<=1 (held until reset).
- arith_in_s holds its last value when no job is accepted.

Pipeline tracking:
- vld[k]<=vld[k-1] every clock.
- At an edge where vld[PIPE_LAT-1]=1, arith_sqrt is pushed into the FIFO.
- Operand-to-push latency = PIPE_LAT clocks after the accept edge. Back-to-back accepts on consecutive cycles are supported.

FIFO:
- Circular buffer with wrap-around of read/write pointers.
- Push and pop on the same edge are both performed; level is unchanged.
- Push when full cannot occur by construction (credit rule). The bench asserts this never happens.

Transmit FSM, states IDLE, LAUNCH_WAIT, FRAME_WAIT:
- IDLE: if fifo_level>0 and tx_idle=1, then out_data<=FIFO head, pop, out_data_ready<=1 for exactly one clock, timer<=0, go LAUNCH_WAIT.
- LAUNCH_WAIT: out_data_ready=0.
  - tx_idle=0: go FRAME_WAIT.
  - Otherwise timer++; when timer reaches TX_ACK_TO, go IDLE (frame assumed done).
- FRAME_WAIT: when tx_idle=1, go IDLE.
- The next launch is earliest one clock after re-entering IDLE. out_data changes only on a launch.
- A push and a launch-pop in the same cycle are handled per the FIFO rule.

Optional Feature:
Macro SQRT_SCHED_STATS_EN.
- Defined: adds output ports stat_jobs [15:0] and stat_drops [7:0], both reset to 0.
  - stat_jobs increments on every launch pulse and wraps at 16 bits.
  - stat_drops increments on every refused job and saturates at 255.
- Undefined: these ports and their counters are absent; behaviour is otherwise identical.

Test Plan:
1. Single job, PIPE_LAT=4, tx_idle=1: in_data=0x00000100 pulse at cycle 0 -> arith_in_s=0x100 after edge 0; FIFO push at edge 4 capturing model sqrt 0x10; out_data=0x10 and one-cycle out_data_ready at edge 5.
2. Back-to-back: 4 pulses on consecutive cycles with operands 1,4,9,16, tx_idle forced 0 -> fifo_level reaches 4, no drop. Releasing tx_idle -> outputs 1,2,3,4 in order, one launch per frame.
3. Credit exhaustion, FIFO_DEPTH=4, tx_idle=0: 5 pulses -> 5th refused, drop_err=1; with STATS_EN, stat_drops=1; arith_in_s keeps 4th operand.
4. Handshake: after launch, transmitter model holds tx_idle=0 for 40 cycles -> no second pulse until 1 clock after tx_idle returns to 1. Never-busy transmitter -> next launch after TX_ACK_TO timeout.
5. Reset mid-operation: rst_n=0 for 1 cycle while 2 jobs are in flight and 1 is queued -> fifo_level=0, no launch in the next 10 cycles, drop_err=0.
6. Simultaneous push and pop with fifo_level=1 -> level stays 1 and data order is preserved across pointer wrap (run 3×FIFO_DEPTH jobs).
